// File: rtl/dict_rom_arbiter.sv
// Two-port round-robin arbiter in front of the single-port dictionary ROM.
// Port 0 is the CPU and port 1 is the word-scan engine; each returned word goes back to the port that issued its read.
module dict_rom_arbiter #(
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4,
  parameter int AW        = 12,
  parameter int DW        = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_dout,
  output logic          busy
);

  localparam int CW = 4;

  typedef enum logic {
    OWNER_P0 = 1'b0,
    OWNER_P1 = 1'b1
  } owner_e;

  owner_e              ptr_q, ptr_d;
  owner_e              last_q, last_d;
  logic                last_vld_q, last_vld_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [RD_LAT-1:0]   tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0]   tag_own_q, tag_own_d;
  logic [DW-1:0]       hold0_q, hold0_d;
  logic [DW-1:0]       hold1_q, hold1_d;

  owner_e              sel;
  logic                accept;
  logic                cap_hit;
  logic                resp_vld;
  logic                resp_own;

  // Arbitration: a lone requester always wins; on a tie the pointer decides,
  // unless the last owner has used up its burst allowance.
  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    sel     = OWNER_P0;
    accept  = 1'b0;
    cap_hit = last_vld_q && (cnt_q == CW'(MAX_BURST));
    if (!reset) begin
      accept = req0 || req1;
      if (req0 && req1) begin
        sel = cap_hit ? owner_e'(~last_q) : ptr_q;
      end else if (req1) begin
        sel = OWNER_P1;
      end
    end
    gnt0 = accept && (sel == OWNER_P0);
    gnt1 = accept && (sel == OWNER_P1);
  end

  always_comb begin
    rom_addr = addr_q;
    if (reset) begin
      rom_addr = '0;
    end else if (accept) begin
      rom_addr = (sel == OWNER_P1) ? addr1 : addr0;
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    if (accept) begin
      addr_d     = rom_addr;
      last_d     = sel;
      last_vld_d = 1'b1;
      ptr_d      = owner_e'(~sel);
      if (last_vld_q && (last_q == sel)) begin
        cnt_d = (cnt_q == CW'(MAX_BURST)) ? cnt_q : cnt_q + CW'(1);
      end else begin
        cnt_d = CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Each stage of the tag pipeline holds one in-flight read: a valid bit and the owner that issued it.
  always_comb begin
    tag_vld_d    = '0;
    tag_own_d    = '0;
    tag_vld_d[0] = accept;
    tag_own_d[0] = sel;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  always_comb begin
    resp_vld = tag_vld_q[RD_LAT-1] && !reset;
    resp_own = tag_own_q[RD_LAT-1];
    rvalid0  = resp_vld && (resp_own == OWNER_P0);
    rvalid1  = resp_vld && (resp_own == OWNER_P1);
    rdata0   = rvalid0 ? rom_dout : hold0_q;
    rdata1   = rvalid1 ? rom_dout : hold1_q;
    hold0_d  = rdata0;
    hold1_d  = rdata1;
    busy     = !reset && (|tag_vld_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q      <= OWNER_P0;
      last_q     <= OWNER_P0;
      last_vld_q <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      tag_vld_q  <= '0;
      tag_own_q  <= '0;
      hold0_q    <= '0;
      hold1_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      tag_vld_q  <= tag_vld_d;
      tag_own_q  <= tag_own_d;
      hold0_q    <= hold0_d;
      hold1_q    <= hold1_d;
    end
  end

endmodule

// File: tb/tb_dict_rom_arbiter.sv
// Directed bench for dict_rom_arbiter: three instances (RD_LAT = 1, 3, 2) share the same stimulus,
// and each instance has its own behavioural ROM with the matching read latency.
module tb_dict_rom_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NI = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0  = 1'b0;
  logic          req1  = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;

  logic [NI-1:0] gnt0_w, gnt1_w, rvalid0_w, rvalid1_w, busy_w;
  logic [DW-1:0] rdata0_w   [NI];
  logic [DW-1:0] rdata1_w   [NI];
  logic [DW-1:0] rom_dout_w [NI];
  logic [AW-1:0] rom_addr_w [NI];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a, 8'h5A, ~a};
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 2;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 2;
    logic [AW-1:0] pipe [4];

    always @(posedge clock) begin
      pipe[0] <= rom_addr_w[g];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign rom_dout_w[g] = rom_word(pipe[L-1]);

    dict_rom_arbiter #(.RD_LAT(L), .MAX_BURST(4), .AW(AW), .DW(DW)) u_dut (
      .clock    (clock),
      .reset    (reset),
      .req0     (req0),
      .addr0    (addr0),
      .gnt0     (gnt0_w[g]),
      .rvalid0  (rvalid0_w[g]),
      .rdata0   (rdata0_w[g]),
      .req1     (req1),
      .addr1    (addr1),
      .gnt1     (gnt1_w[g]),
      .rvalid1  (rvalid1_w[g]),
      .rdata1   (rdata1_w[g]),
      .rom_addr (rom_addr_w[g]),
      .rom_dout (rom_dout_w[g]),
      .busy     (busy_w[g])
    );
  end

  // Inputs change at the falling edge; outputs are sampled 1 ns later, well away from the rising edge.
  task automatic drive(input logic r0, input logic [AW-1:0] a0, input logic r1, input logic [AW-1:0] a1);
    @(negedge clock);
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 12'h123; addr1 = 12'h456;
    repeat (4) @(negedge clock);
    #1;
    checks++; if (gnt0_w !== 3'b000) begin failures++; $display("FAIL reset_gnt0: got %b expected 000", gnt0_w); end
    checks++; if (gnt1_w !== 3'b000) begin failures++; $display("FAIL reset_gnt1: got %b expected 000", gnt1_w); end
    checks++; if ((rvalid0_w | rvalid1_w) !== 3'b000) begin failures++; $display("FAIL reset_rvalid: got %b/%b expected 000/000", rvalid0_w, rvalid1_w); end
    checks++; if (busy_w !== 3'b000) begin failures++; $display("FAIL reset_busy: got %b expected 000", busy_w); end
    for (int g = 0; g < NI; g++) begin
      checks++; if (rom_addr_w[g] !== 12'h000) begin failures++; $display("FAIL reset_rom_addr[%0d]: got %h expected 000", g, rom_addr_w[g]); end
    end
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_single();
    do_reset(2);
    drive(1'b1, 12'h005, 1'b0, 12'h000);
    checks++; if (gnt0_w[0] !== 1'b1) begin failures++; $display("FAIL single_gnt0: got %b expected 1", gnt0_w[0]); end
    checks++; if (gnt1_w[0] !== 1'b0) begin failures++; $display("FAIL single_gnt1: got %b expected 0", gnt1_w[0]); end
    checks++; if (rom_addr_w[0] !== 12'h005) begin failures++; $display("FAIL single_rom_addr: got %h expected 005", rom_addr_w[0]); end
    drive(1'b0, 12'h3FF, 1'b0, 12'h000);
    checks++; if (rvalid0_w[0] !== 1'b1) begin failures++; $display("FAIL single_rvalid0: got %b expected 1", rvalid0_w[0]); end
    checks++; if (rdata0_w[0] !== rom_word(12'h005)) begin failures++; $display("FAIL single_rdata0: got %h expected %h", rdata0_w[0], rom_word(12'h005)); end
    checks++; if (rvalid1_w[0] !== 1'b0) begin failures++; $display("FAIL single_rvalid1: got %b expected 0", rvalid1_w[0]); end
    checks++; if (rom_addr_w[0] !== 12'h005) begin failures++; $display("FAIL single_addr_hold: got %h expected 005", rom_addr_w[0]); end
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    checks++; if ({rvalid0_w[0], rvalid1_w[0]} !== 2'b00) begin failures++; $display("FAIL single_rvalid_after: got %b%b expected 00", rvalid0_w[0], rvalid1_w[0]); end
    checks++; if (rdata0_w[0] !== rom_word(12'h005)) begin failures++; $display("FAIL single_rdata0_hold: got %h expected %h", rdata0_w[0], rom_word(12'h005)); end
  endtask

  task automatic test_alternate();
    do_reset(4);
    for (int k = 0; k < 8; k++) begin
      drive(k < 4, 12'h010, k < 4, 12'h020);
      if (k < 4) begin
        checks++; if (gnt0_w !== {NI{k % 2 == 0}}) begin failures++; $display("FAIL alt_gnt0 cycle %0d: got %b", k, gnt0_w); end
        checks++; if (gnt1_w !== {NI{k % 2 == 1}}) begin failures++; $display("FAIL alt_gnt1 cycle %0d: got %b", k, gnt1_w); end
      end
      for (int g = 0; g < NI; g++) begin
        int  j;
        logic v0, v1;
        j  = k - lat_of(g);
        v0 = (j >= 0) && (j < 4) && (j % 2 == 0);
        v1 = (j >= 0) && (j < 4) && (j % 2 == 1);
        checks++; if (rvalid0_w[g] !== v0) begin failures++; $display("FAIL alt_rvalid0 inst %0d cycle %0d: got %b expected %b", g, k, rvalid0_w[g], v0); end
        checks++; if (rvalid1_w[g] !== v1) begin failures++; $display("FAIL alt_rvalid1 inst %0d cycle %0d: got %b expected %b", g, k, rvalid1_w[g], v1); end
        if (v0) begin
          checks++; if (rdata0_w[g] !== rom_word(12'h010)) begin failures++; $display("FAIL alt_rdata0 inst %0d: got %h expected %h", g, rdata0_w[g], rom_word(12'h010)); end
        end
        if (v1) begin
          checks++; if (rdata1_w[g] !== rom_word(12'h020)) begin failures++; $display("FAIL alt_rdata1 inst %0d: got %h expected %h", g, rdata1_w[g], rom_word(12'h020)); end
        end
      end
    end
  endtask

  task automatic test_burst_yield();
    do_reset(4);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, AW'(12'h100 + k), 1'b0, 12'h000);
      checks++; if (gnt0_w[0] !== 1'b1) begin failures++; $display("FAIL yield_pre_gnt0 %0d: got %b expected 1", k, gnt0_w[0]); end
    end
    drive(1'b1, 12'h102, 1'b1, 12'h200);
    checks++; if ({gnt0_w[0], gnt1_w[0]} !== 2'b01) begin failures++; $display("FAIL yield_gnt1: got gnt0/gnt1 %b%b expected 01", gnt0_w[0], gnt1_w[0]); end
    checks++; if (rom_addr_w[0] !== 12'h200) begin failures++; $display("FAIL yield_rom_addr: got %h expected 200", rom_addr_w[0]); end
    for (int k = 3; k < 9; k++) begin
      drive(1'b1, AW'(12'h100 + k), 1'b0, 12'h000);
      checks++; if (gnt0_w[0] !== 1'b1) begin failures++; $display("FAIL yield_run_gnt0 %0d: got %b expected 1", k, gnt0_w[0]); end
    end
  endtask

  task automatic test_cap();
    do_reset(4);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, AW'(12'h040 + k), 1'b0, 12'h000);
      checks++; if (gnt0_w[0] !== 1'b1) begin failures++; $display("FAIL cap_burst_gnt0 %0d: got %b expected 1", k, gnt0_w[0]); end
    end
    drive(1'b1, 12'h044, 1'b1, 12'h055);
    checks++; if ({gnt0_w[0], gnt1_w[0]} !== 2'b01) begin failures++; $display("FAIL cap_switch: got gnt0/gnt1 %b%b expected 01", gnt0_w[0], gnt1_w[0]); end
    drive(1'b1, 12'h044, 1'b1, 12'h056);
    checks++; if ({gnt0_w[0], gnt1_w[0]} !== 2'b10) begin failures++; $display("FAIL cap_return: got gnt0/gnt1 %b%b expected 10", gnt0_w[0], gnt1_w[0]); end
  endtask

  task automatic test_back_to_back_lat3();
    logic [6:0] exp_busy;
    exp_busy = 7'b0111110;
    do_reset(4);
    drive(1'b1, 12'h001, 1'b0, 12'h000);
    checks++; if (gnt0_w[1] !== 1'b1) begin failures++; $display("FAIL b2b_gnt_c0: got %b expected 1", gnt0_w[1]); end
    drive(1'b0, 12'h000, 1'b1, 12'h002);
    checks++; if (gnt1_w[1] !== 1'b1) begin failures++; $display("FAIL b2b_gnt_c1: got %b expected 1", gnt1_w[1]); end
    drive(1'b1, 12'h003, 1'b0, 12'h000);
    checks++; if (gnt0_w[1] !== 1'b1) begin failures++; $display("FAIL b2b_gnt_c2: got %b expected 1", gnt0_w[1]); end
    for (int k = 3; k < 7; k++) begin
      if (k > 3) drive(1'b0, 12'h000, 1'b0, 12'h000);
      else begin @(negedge clock); req0 = 1'b0; req1 = 1'b0; #1; end
      checks++; if (busy_w[1] !== exp_busy[k]) begin failures++; $display("FAIL b2b_busy c%0d: got %b expected %b", k, busy_w[1], exp_busy[k]); end
      checks++; if (rvalid0_w[1] !== (k == 3 || k == 5)) begin failures++; $display("FAIL b2b_rvalid0 c%0d: got %b", k, rvalid0_w[1]); end
      checks++; if (rvalid1_w[1] !== (k == 4)) begin failures++; $display("FAIL b2b_rvalid1 c%0d: got %b", k, rvalid1_w[1]); end
    end
    // Data words were checked implicitly through the held registers: port 0 holds ROM[3], port 1 holds ROM[2].
    checks++; if (rdata0_w[1] !== rom_word(12'h003)) begin failures++; $display("FAIL b2b_rdata0: got %h expected %h", rdata0_w[1], rom_word(12'h003)); end
    checks++; if (rdata1_w[1] !== rom_word(12'h002)) begin failures++; $display("FAIL b2b_rdata1: got %h expected %h", rdata1_w[1], rom_word(12'h002)); end
  endtask

  task automatic test_lat3_data();
    do_reset(4);
    drive(1'b1, 12'h001, 1'b0, 12'h000);
    drive(1'b0, 12'h000, 1'b1, 12'h002);
    drive(1'b1, 12'h003, 1'b0, 12'h000);
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    checks++; if (rdata0_w[1] !== rom_word(12'h001)) begin failures++; $display("FAIL lat3_data c3: got %h expected %h", rdata0_w[1], rom_word(12'h001)); end
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    checks++; if (rdata1_w[1] !== rom_word(12'h002)) begin failures++; $display("FAIL lat3_data c4: got %h expected %h", rdata1_w[1], rom_word(12'h002)); end
    checks++; if (rdata0_w[1] !== rom_word(12'h001)) begin failures++; $display("FAIL lat3_hold0 c4: got %h expected %h", rdata0_w[1], rom_word(12'h001)); end
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    checks++; if (rdata0_w[1] !== rom_word(12'h003)) begin failures++; $display("FAIL lat3_data c5: got %h expected %h", rdata0_w[1], rom_word(12'h003)); end
  endtask

  task automatic test_reset_mid();
    do_reset(4);
    drive(1'b1, 12'h0AB, 1'b0, 12'h000);
    checks++; if (gnt0_w[2] !== 1'b1) begin failures++; $display("FAIL rmid_gnt: got %b expected 1", gnt0_w[2]); end
    @(negedge clock);
    reset = 1'b1; req0 = 1'b1; addr0 = 12'h007; req1 = 1'b1; addr1 = 12'h008;
    #1;
    checks++; if ((gnt0_w | gnt1_w) !== 3'b000) begin failures++; $display("FAIL rmid_gnt_in_reset: got %b/%b expected 000/000", gnt0_w, gnt1_w); end
    checks++; if ((rvalid0_w | rvalid1_w) !== 3'b000) begin failures++; $display("FAIL rmid_rvalid_in_reset: got %b/%b expected 000/000", rvalid0_w, rvalid1_w); end
    @(negedge clock);
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    #1;
    checks++; if ({rvalid0_w[2], rvalid1_w[2]} !== 2'b00) begin failures++; $display("FAIL rmid_rvalid_n2: got %b%b expected 00", rvalid0_w[2], rvalid1_w[2]); end
    checks++; if (busy_w[2] !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b expected 0", busy_w[2]); end
    checks++; if (rom_addr_w[2] !== 12'h000) begin failures++; $display("FAIL rmid_rom_addr: got %h expected 000", rom_addr_w[2]); end
    drive(1'b1, 12'h011, 1'b1, 12'h022);
    checks++; if ({gnt0_w[2], gnt1_w[2]} !== 2'b10) begin failures++; $display("FAIL rmid_priority: got gnt0/gnt1 %b%b expected 10", gnt0_w[2], gnt1_w[2]); end
    checks++; if (rom_addr_w[2] !== 12'h011) begin failures++; $display("FAIL rmid_next_addr: got %h expected 011", rom_addr_w[2]); end
    drive(1'b0, 12'h000, 1'b0, 12'h000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_burst_yield();
    test_cap();
    test_back_to_back_lat3();
    test_lat3_data();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
